seg7_pattern_decoder: RTL and testbench

- Receiver for the active-low two-digit 7-segment buses produced by the team's LED7-style display drivers; recovers digit values from the segment patterns.
- Synchronises both buses, requires each pattern to hold stable for a programmable number of cycles, validates it against the legal glyph set, and publishes the decoded digits, a binary value and status flags.
- Used as a loopback checker and observer on display outputs in the final_project top level.

---
 rtl/seg7_pattern_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: recovers two digit values from active-low 7-segment
// buses. Each bus is synchronised, must hold stable for STABLE_CYCLES samples,
// and is then checked against the legal glyph set before the outputs update.
// Build option: define SEG7_HEX_EN to accept the hex glyphs A..F (values
// 10..15) and publish bin as digit1*16 + digit0. Without it, bin is decimal.
//
// state  | meaning
// IDLE   | nothing has settled since reset; leave only on a sample change
// SETTLE | sample changed; counting consecutive identical samples
// HOLD   | current pattern evaluated; wait for the next change
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:6] seg0_n,
  input  logic [0:6] seg1_n,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       blank0,
  output logic       blank1,
  output logic [7:0] bin,
  output logic       locked,
  output logic       upd_p,
  output logic       pat_err,
  output logic       err_p
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [8:0] STABLE_W = 9'(STABLE_CYCLES);

  // Result layout: {legal, blank, value[3:0]}; pattern bit 6 = a .. bit 0 = g.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = {2'b10, 4'd0};
      7'b0110000: decode = {2'b10, 4'd1};
      7'b1101101: decode = {2'b10, 4'd2};
      7'b1111001: decode = {2'b10, 4'd3};
      7'b0110011: decode = {2'b10, 4'd4};
      7'b1011011: decode = {2'b10, 4'd5};
      7'b1011111: decode = {2'b10, 4'd6};
      7'b1110000: decode = {2'b10, 4'd7};
      7'b1111111: decode = {2'b10, 4'd8};
      7'b1111011: decode = {2'b10, 4'd9};
      7'b0000000: decode = {2'b11, 4'd0};
`ifdef SEG7_HEX_EN
      7'b1110111: decode = {2'b10, 4'd10};
      7'b0011111: decode = {2'b10, 4'd11};
      7'b1001110: decode = {2'b10, 4'd12};
      7'b0111101: decode = {2'b10, 4'd13};
      7'b1001111: decode = {2'b10, 4'd14};
      7'b1000111: decode = {2'b10, 4'd15};
`endif
      default:    decode = 6'b000000;
    endcase
  endfunction

  logic [13:0] sync_q [SYNC_STAGES];
  logic [13:0] samp;
  logic [13:0] prev_q;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_inc;
  logic [5:0]  dec0, dec1;
  logic [3:0]  digit0_d, digit1_d;
  logic        blank0_d, blank1_d, locked_d, pat_err_d, upd_d, err_d;
  logic [7:0]  bin_d;

  assign samp    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign dec0    = decode(~samp[6:0]);
  assign dec1    = decode(~samp[13:7]);

  // Synchroniser chain plus the previous-sample register used for change detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= {seg1_n, seg0_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= samp;
    end
  end

  // State, stability counter and published outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      digit0  <= '0;
      digit1  <= '0;
      blank0  <= 1'b0;
      blank1  <= 1'b0;
      bin     <= '0;
      locked  <= 1'b0;
      pat_err <= 1'b0;
      upd_p   <= 1'b0;
      err_p   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit0  <= digit0_d;
      digit1  <= digit1_d;
      blank0  <= blank0_d;
      blank1  <= blank1_d;
      bin     <= bin_d;
      locked  <= locked_d;
      pat_err <= pat_err_d;
      upd_p   <= upd_d;
      err_p   <= err_d;
    end
  end

  // Next-state logic; evaluation happens on the edge the count completes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit0_d  = digit0;
    digit1_d  = digit1;
    blank0_d  = blank0;
    blank1_d  = blank1;
    bin_d     = bin;
    locked_d  = locked;
    pat_err_d = pat_err;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (samp != prev_q) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (samp != prev_q) begin
          cnt_d = 8'd1;
        end else if (cnt_inc >= STABLE_W) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (dec0[5] && dec1[5]) begin
            digit0_d  = dec0[3:0];
            digit1_d  = dec1[3:0];
            blank0_d  = dec0[4];
            blank1_d  = dec1[4];
`ifdef SEG7_HEX_EN
            bin_d     = {dec1[3:0], dec0[3:0]};
`else
            bin_d     = ({4'd0, dec1[3:0]} << 3) + ({4'd0, dec1[3:0]} << 1)
                        + {4'd0, dec0[3:0]};
`endif
            locked_d  = 1'b1;
            pat_err_d = 1'b0;
            upd_d     = 1'b1;
          end else begin
            pat_err_d = 1'b1;
            err_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed testbench for seg7_pattern_decoder (default parameters).
module tb_seg7_pattern_decoder;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] G9 = 7'b1111011;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] GB = 7'b0000000;
  localparam logic [6:0] GX = 7'b1010101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] seg0_n, seg1_n;
  logic [3:0] digit0, digit1;
  logic       blank0, blank1;
  logic [7:0] bin;
  logic       locked, upd_p, pat_err, err_p;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_pattern_decoder dut (
    .clk(clk), .rst_n(rst_n), .seg0_n(seg0_n), .seg1_n(seg1_n),
    .digit0(digit0), .digit1(digit1), .blank0(blank0), .blank1(blank1),
    .bin(bin), .locked(locked), .upd_p(upd_p), .pat_err(pat_err), .err_p(err_p)
  );

  always #5 clk = ~clk;

  // Drive active-high glyphs just after an edge; the following edge is E1.
  task automatic drive(input logic [6:0] s1, input logic [6:0] s0);
    @(posedge clk); #1;
    seg1_n = ~s1;
    seg0_n = ~s0;
  endtask

  // Count edges until the first pulse; 0 means that pulse was not seen.
  task automatic wait_pulse(input int budget, output int e_upd, output int e_err);
    e_upd = 0;
    e_err = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (upd_p) e_upd = i;
      if (err_p) e_err = i;
      if (e_upd != 0 || e_err != 0) break;
    end
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      seg0_n = 7'($urandom);
      seg1_n = 7'($urandom);
      n_checks++;
      if ({digit0, digit1, blank0, blank1, bin, locked, upd_p, pat_err, err_p} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got d1=%0d d0=%0d bin=%0d lk=%b upd=%b perr=%b errp=%b, want all 0",
                 i, digit1, digit0, bin, locked, upd_p, pat_err, err_p);
      end
    end
    seg0_n = 7'h7F;
    seg1_n = 7'h7F;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (upd_p || err_p || locked || pat_err) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d cycles with activity, want 0", pulses);
    end
  endtask

  task automatic test_stable();
    int eu, ee;
    drive(G0, G3);
    wait_pulse(20, eu, ee);
    n_checks++;
    if (eu !== 6 || ee !== 0) begin
      n_fail++;
      $display("FAIL stable_latency: got upd edge %0d err edge %0d, want 6 and 0", eu, ee);
    end
    n_checks++;
    if ({digit1, digit0, bin, locked, pat_err, blank1, blank0} !== {4'd0, 4'd3, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stable_value: got d1=%0d d0=%0d bin=%0d lk=%b perr=%b b1=%b b0=%b, want 0 3 3 1 0 0 0",
               digit1, digit0, bin, locked, pat_err, blank1, blank0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (upd_p !== 1'b0) begin
      n_fail++;
      $display("FAIL stable_pulse_width: got upd_p=%b one cycle later, want 0", upd_p);
    end
  endtask

  task automatic test_glitch();
    int eu, ee;
    int pulses = 0;
    drive(G4, G2);
    wait_pulse(20, eu, ee);
    n_checks++;
    if (eu !== 6 || bin !== 8'd42) begin
      n_fail++;
      $display("FAIL glitch_setup: got upd edge %0d bin=%0d, want 6 and 42", eu, bin);
    end
    drive(G4, G7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (upd_p || err_p) pulses++;
    end
    seg0_n = ~G2;
    wait_pulse(20, eu, ee);
    n_checks++;
    if (pulses !== 0 || eu !== 6 || ee !== 0) begin
      n_fail++;
      $display("FAIL glitch_filter: got %0d early pulses, upd edge %0d err edge %0d, want 0, 6, 0", pulses, eu, ee);
    end
    n_checks++;
    if (bin !== 8'd42 || digit0 !== 4'd2) begin
      n_fail++;
      $display("FAIL glitch_value: got bin=%0d d0=%0d, want 42 and 2", bin, digit0);
    end
  endtask

  task automatic test_illegal();
    int eu, ee;
    drive(G4, GX);
    wait_pulse(20, eu, ee);
    n_checks++;
    if (ee !== 6 || eu !== 0) begin
      n_fail++;
      $display("FAIL illegal_latency: got err edge %0d upd edge %0d, want 6 and 0", ee, eu);
    end
    n_checks++;
    if ({pat_err, locked, digit1, digit0, bin} !== {1'b1, 1'b1, 4'd4, 4'd2, 8'd42}) begin
      n_fail++;
      $display("FAIL illegal_hold: got perr=%b lk=%b d1=%0d d0=%0d bin=%0d, want 1 1 4 2 42",
               pat_err, locked, digit1, digit0, bin);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err_p !== 1'b0 || pat_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_pulse_width: got err_p=%b pat_err=%b, want 0 and 1", err_p, pat_err);
    end
    drive(G4, G9);
    wait_pulse(20, eu, ee);
    n_checks++;
    if (eu !== 6 || ee !== 0 || pat_err !== 1'b0 || digit0 !== 4'd9 || bin !== 8'd49) begin
      n_fail++;
      $display("FAIL illegal_recover: got upd %0d err %0d perr=%b d0=%0d bin=%0d, want 6 0 0 9 49",
               eu, ee, pat_err, digit0, bin);
    end
  endtask

  task automatic test_blank_reset();
    int eu, ee;
    int pulses = 0;
    drive(GB, G5);
    wait_pulse(20, eu, ee);
    n_checks++;
    if (eu !== 6 || {blank1, blank0, digit1, digit0, bin} !== {1'b1, 1'b0, 4'd0, 4'd5, 8'd5}) begin
      n_fail++;
      $display("FAIL blank_value: got upd %0d b1=%b b0=%b d1=%0d d0=%0d bin=%0d, want 6 1 0 0 5 5",
               eu, blank1, blank0, digit1, digit0, bin);
    end
    drive(GB, G8);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (upd_p || err_p) pulses++;
    end
    rst_n  = 1'b0;
    seg0_n = 7'h7F;
    seg1_n = 7'h7F;
    @(posedge clk); #1;
    n_checks++;
    if ({digit0, digit1, blank0, blank1, bin, locked, upd_p, pat_err, err_p} !== 22'd0) begin
      n_fail++;
      $display("FAIL midsettle_reset: got d1=%0d d0=%0d b1=%b bin=%0d lk=%b upd=%b perr=%b errp=%b, want all 0",
               digit1, digit0, blank1, bin, locked, upd_p, pat_err, err_p);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (upd_p || err_p) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL midsettle_discard: got %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_hex();
    int eu, ee;
    drive(GA, GF);
    wait_pulse(20, eu, ee);
`ifdef SEG7_HEX_EN
    n_checks++;
    if (eu !== 6 || ee !== 0 || {digit1, digit0, bin, locked, pat_err} !== {4'd10, 4'd15, 8'd175, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hex_value: got upd %0d err %0d d1=%0d d0=%0d bin=%0d lk=%b perr=%b, want 6 0 10 15 175 1 0",
               eu, ee, digit1, digit0, bin, locked, pat_err);
    end
`else
    n_checks++;
    if (ee !== 6 || eu !== 0 || {pat_err, locked, bin} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL hex_illegal: got err %0d upd %0d perr=%b lk=%b bin=%0d, want 6 0 1 0 0",
               ee, eu, pat_err, locked, bin);
    end
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    seg0_n = 7'h7F;
    seg1_n = 7'h7F;
    test_reset();
    test_stable();
    test_glitch();
    test_illegal();
    test_blank_reset();
    test_hex();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
